// File: rtl/npc_exec_sequencer_pkg.sv
// rtl/npc_exec_sequencer_pkg.sv - shared types and constants for the npc execution sequencer
// Purpose: sequencer state encoding, the canonical nop word and the default reset PC.
// Ports: none (package npc_pkg).
package npc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT,
        ERR
    } seq_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

    // HALT and ERR are sinks; only reset leaves them.
    function automatic logic is_terminal(input seq_state_e s);
        return (s == HALT) || (s == ERR);
    endfunction

endpackage

// File: rtl/npc_exec_sequencer_if.sv
// rtl/npc_exec_sequencer_if.sv - IFU instruction-fetch port between sequencer and memory
// Purpose: groups the fetch request/address and the returned instruction word.
// Ports (signals): ifu_req, ifu_addr[XLEN] (sequencer -> memory);
//                  ifu_rvalid, ifu_rdata[32] (memory -> sequencer).
// Modports: master = sequencer side, slave = memory side.
interface npc_exec_sequencer_if #(
    parameter int XLEN = 64
) ();

    logic            ifu_req;
    logic [XLEN-1:0] ifu_addr;
    logic            ifu_rvalid;
    logic [31:0]     ifu_rdata;

    modport master (
        output ifu_req,
        output ifu_addr,
        input  ifu_rvalid,
        input  ifu_rdata
    );

    modport slave (
        input  ifu_req,
        input  ifu_addr,
        output ifu_rvalid,
        output ifu_rdata
    );

endinterface

// File: rtl/npc_exec_sequencer_watchdog.sv
// rtl/npc_exec_sequencer_watchdog.sv - saturating fetch-wait counter for the sequencer
// Purpose: counts FETCH cycles without returned data and flags the last permitted wait cycle.
// Ports: clk, i_rst (sync, active-high), i_clear, i_inc in; o_expired out.
module npc_seq_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A miss in this cycle brings the count to MEM_TIMEOUT, so the FSM
    // leaves FETCH on the same edge the count reaches the limit.
    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/npc_exec_sequencer.sv
// rtl/npc_exec_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/WB control FSM for npc-riscv64
// Purpose: owns the PC, latches the fetched word for the decoder, strobes decode,
//          gates register-file writeback and stops on ebreak (halted) or fault (err).
// Ports: clk, rst (sync, active-high); ifu (npc_exec_sequencer_if.master fetch port);
//        o_inst, o_idu_en to the decoder; i_reg_wr_req, i_halt_req, i_illegal from the decoder;
//        i_exu_done, i_next_pc from the EXU; o_rf_we to the register file;
//        o_pc, o_halted, o_err status.
//        With NPC_SEQ_PERF_CNT_EN defined: o_cycle_cnt, o_instret_cnt performance counters.
module npc_exec_sequencer
    import npc_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
    parameter int              MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    npc_exec_sequencer_if.master  ifu,
    output logic [31:0]           o_inst,
    output logic                  o_idu_en,
    input  logic                  i_reg_wr_req,
    input  logic                  i_halt_req,
    input  logic                  i_illegal,
    input  logic                  i_exu_done,
    input  logic [XLEN-1:0]       i_next_pc,
    output logic                  o_rf_we,
    output logic [XLEN-1:0]       o_pc,
    output logic                  o_halted,
    output logic                  o_err
`ifdef NPC_SEQ_PERF_CNT_EN
    ,
    output logic [63:0]           o_cycle_cnt,
    output logic [63:0]           o_instret_cnt
`endif
);

    seq_state_e      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_npc;
    logic [31:0]     r_inst;
    logic            r_wr_pend;
    logic            r_ifu_req;
    logic            r_idu_en;
    logic            r_rf_we;
    logic            r_halted;
    logic            r_err;

    logic w_in_fetch;
    logic w_wd_clear;
    logic w_wd_inc;
    logic w_wd_expired;

    assign w_in_fetch = (r_state == FETCH);
    assign w_wd_clear = w_in_fetch && ifu.ifu_rvalid;
    assign w_wd_inc   = w_in_fetch && !ifu.ifu_rvalid;

    npc_seq_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .i_rst     (rst),
        .i_clear   (w_wd_clear),
        .i_inc     (w_wd_inc),
        .o_expired (w_wd_expired)
    );

    // Strobes are registered: each is set on the edge entering the state
    // that owns it and cleared on the edge leaving it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_npc     <= RESET_PC;
            r_inst    <= NOP_INST;
            r_wr_pend <= 1'b0;
            r_ifu_req <= 1'b0;
            r_idu_en  <= 1'b0;
            r_rf_we   <= 1'b0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state   <= FETCH;
                    r_ifu_req <= 1'b1;
                end
                FETCH: begin
                    // Data arriving on the final wait cycle still wins over the timeout.
                    if (ifu.ifu_rvalid) begin
                        r_inst    <= ifu.ifu_rdata;
                        r_ifu_req <= 1'b0;
                        r_idu_en  <= 1'b1;
                        r_state   <= DECODE;
                    end else if (w_wd_expired) begin
                        r_ifu_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ERR;
                    end
                end
                DECODE: begin
                    r_idu_en  <= 1'b0;
                    r_wr_pend <= i_reg_wr_req;
                    if (i_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= ERR;
                    end else if (i_halt_req) begin
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end else begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (i_exu_done) begin
                        // Misaligned target faults before the PC moves, so pc
                        // keeps pointing at the offending instruction.
                        if (i_next_pc[1:0] != 2'b00) begin
                            r_err   <= 1'b1;
                            r_state <= ERR;
                        end else begin
                            r_npc   <= i_next_pc;
                            r_rf_we <= r_wr_pend;
                            r_state <= WB;
                        end
                    end
                end
                WB: begin
                    r_rf_we   <= 1'b0;
                    r_pc      <= r_npc;
                    r_ifu_req <= 1'b1;
                    r_state   <= FETCH;
                end
                HALT, ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef NPC_SEQ_PERF_CNT_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;
    logic        w_retire;

    // An ebreak retires on its way into HALT even though it never reaches WB.
    assign w_retire = (r_state == WB) ||
                      ((r_state == DECODE) && !i_illegal && i_halt_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (!is_terminal(r_state)) begin
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            end
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + 64'd1;
            end
        end
    end

    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;
`endif

    assign ifu.ifu_req  = r_ifu_req;
    assign ifu.ifu_addr = r_pc;
    assign o_inst       = r_inst;
    assign o_idu_en     = r_idu_en;
    assign o_rf_we      = r_rf_we;
    assign o_pc         = r_pc;
    assign o_halted     = r_halted;
    assign o_err        = r_err;

endmodule
